demux1_4_router: RTL

- Buffered 1-to-4 demultiplexer for the 32-bit ALU datapath, moving data the opposite way to the 4:1 operand/result multiplexer.
- Accepts one word per cycle on a valid/ready input channel and steers it by a 2-bit select to one of four output channels.
- Each output channel has a one-entry holding register with its own valid/ready handshake and a wrapping delivered-word counter.
- Sits between the ALU result stage and four downstream consumers (register write, flags, memory, debug).

---
 rtl/demux1_4_router.sv | 86 ++++++++
 1 files changed

// File: rtl/demux1_4_router.sv
// 1-to-4 router: steers each accepted word by {select1,select0} into a one-entry holding register per output channel.
// Latency: a word accepted at edge k is presented with outN_valid=1 in cycle k+1.
// Backpressure: in_ready drops only while the selected channel is full and its consumer is not ready; other channels keep flowing.
module demux1_4_router #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             select1,
    input  logic             select0,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic [WIDTH-1:0] out4_data,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    output logic             out4_valid,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready,
    input  logic             out4_ready,
    output logic [CNTW-1:0]  out1_count,
    output logic [CNTW-1:0]  out2_count,
    output logic [CNTW-1:0]  out3_count,
    output logic [CNTW-1:0]  out4_count
);

    logic [1:0]       sel;
    logic [3:0]       out_rdy;
    logic [3:0]       vld_q;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [WIDTH-1:0] data_q [4];
    logic [CNTW-1:0]  cnt_q  [4];

    assign sel     = {select1, select0};
    assign out_rdy = {out4_ready, out3_ready, out2_ready, out1_ready};

    // A full channel can still take a word in the same cycle its consumer drains it.
    assign in_ready = !vld_q[sel] || out_rdy[sel];
    assign pop      = vld_q & out_rdy;

    always_comb begin
        push      = '0;
        push[sel] = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    data_q[i] <= in_data;
                end
                vld_q[i] <= push[i] | (vld_q[i] & ~pop[i]);
                if (pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNTW'(1);
                end
            end
        end
    end

    assign out1_data  = data_q[0];
    assign out2_data  = data_q[1];
    assign out3_data  = data_q[2];
    assign out4_data  = data_q[3];
    assign out1_valid = vld_q[0];
    assign out2_valid = vld_q[1];
    assign out3_valid = vld_q[2];
    assign out4_valid = vld_q[3];
    assign out1_count = cnt_q[0];
    assign out2_count = cnt_q[1];
    assign out3_count = cnt_q[2];
    assign out4_count = cnt_q[3];

endmodule
